// File: rtl/power_management.sv
// Multi-level power-down sequencer for a single power domain.
//
// Level 1: sustained idle gates the domain clock.
// Level 2: an interrupt (prolonged-idle request) while gated runs
//          isolate -> reset -> power-gate. Dropping idle runs the mirror
//          power-up sequence back to ACTIVE.
//
// Ports:
//   clk          domain clock, rising edge
//   reset        asynchronous active-low reset
//   idle         domain idle indication (level)
//   interrupt    deep power-down request (level)
//   clk_gate     1 = domain clock stopped
//   pg_down      1 = power switch off
//   reset_assert 1 = domain reset held
//   isolation    1 = isolation clamps asserted
//   pm_state     registered state encoding (only with PM_STATE_OBS_EN)
//
// Optional feature macro: PM_STATE_OBS_EN adds the pm_state observation port.
//
// All outputs are registered decodes of the next state, so they change on the
// same edge as the state register and never combinationally follow inputs.
module power_management #(
  parameter int unsigned IDLE_THRESH = 2,
  parameter int unsigned SEQ_DELAY   = 1,
  parameter int unsigned PWRUP_DELAY = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       idle,
  input  logic       interrupt,
  output logic       clk_gate,
  output logic       pg_down,
  output logic       reset_assert,
  output logic       isolation
`ifdef PM_STATE_OBS_EN
  ,
  output logic [2:0] pm_state
`endif
);

  localparam int unsigned StepMax = (PWRUP_DELAY > SEQ_DELAY) ? PWRUP_DELAY : SEQ_DELAY;
  localparam int unsigned StepW   = $clog2(StepMax + 1);
  localparam int unsigned IdleW   = $clog2(IDLE_THRESH + 1);

  localparam logic [StepW-1:0] SeqLast  = StepW'(SEQ_DELAY - 1);
  localparam logic [StepW-1:0] PupLast  = StepW'(PWRUP_DELAY - 1);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IDLE_THRESH - 1);

  typedef enum logic [2:0] {
    StActive = 3'd0,
    StGated  = 3'd1,
    StIso    = 3'd2,
    StRst    = 3'd3,
    StPdn    = 3'd4,
    StPup    = 3'd5,
    StRrel   = 3'd6,
    StIrel   = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [StepW-1:0] step_q, step_d, step_sat;
  logic [IdleW-1:0] idle_cnt_q, idle_cnt_d, idle_cnt_sat;
  logic             clk_gate_q, clk_gate_d;
  logic             isolation_q, isolation_d;
  logic             reset_assert_q, reset_assert_d;
  logic             pg_down_q, pg_down_d;

  // Saturating increments: counters never wrap.
  assign step_sat     = (step_q != {StepW{1'b1}}) ? step_q + StepW'(1) : step_q;
  assign idle_cnt_sat = (idle_cnt_q != {IdleW{1'b1}}) ? idle_cnt_q + IdleW'(1) : idle_cnt_q;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    idle_cnt_d = '0;  // only ACTIVE accumulates idle edges
    unique case (state_q)
      StActive: begin
        if (idle) begin
          if (idle_cnt_q == IdleLast) state_d = StGated;
          else                        idle_cnt_d = idle_cnt_sat;
        end
      end
      StGated: begin
        // idle=0 wins over interrupt
        if (!idle)          state_d = StActive;
        else if (interrupt) state_d = StIso;
      end
      StIso: begin
        if (!idle)                 state_d = StIrel;  // abort before reset
        else if (step_q == SeqLast) state_d = StRst;
        else                       step_d = step_sat;
      end
      StRst: begin
        if (!idle)                 state_d = StRrel;  // abort before power-off
        else if (step_q == SeqLast) state_d = StPdn;
        else                       step_d = step_sat;
      end
      StPdn: begin
        if (!idle) state_d = StPup;
      end
      // Power-up phases are committed: idle is ignored until ACTIVE.
      StPup: begin
        if (step_q == PupLast) state_d = StRrel;
        else                   step_d = step_sat;
      end
      StRrel: begin
        if (step_q == SeqLast) state_d = StIrel;
        else                   step_d = step_sat;
      end
      StIrel: begin
        if (step_q == SeqLast) state_d = StActive;
        else                   step_d = step_sat;
      end
      default: state_d = StActive;
    endcase
    if (state_d != state_q) step_d = '0;
  end

  // Moore decode of the next state; registered below.
  always_comb begin
    clk_gate_d     = (state_d != StActive);
    isolation_d    = (state_d == StIso) || (state_d == StRst) || (state_d == StPdn) ||
                     (state_d == StPup) || (state_d == StRrel);
    reset_assert_d = (state_d == StRst) || (state_d == StPdn) || (state_d == StPup);
    pg_down_d      = (state_d == StPdn);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= StActive;
      step_q         <= '0;
      idle_cnt_q     <= '0;
      clk_gate_q     <= 1'b0;
      isolation_q    <= 1'b0;
      reset_assert_q <= 1'b0;
      pg_down_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_q         <= step_d;
      idle_cnt_q     <= idle_cnt_d;
      clk_gate_q     <= clk_gate_d;
      isolation_q    <= isolation_d;
      reset_assert_q <= reset_assert_d;
      pg_down_q      <= pg_down_d;
    end
  end

  assign clk_gate     = clk_gate_q;
  assign isolation    = isolation_q;
  assign reset_assert = reset_assert_q;
  assign pg_down      = pg_down_q;

`ifdef PM_STATE_OBS_EN
  assign pm_state = state_q;
`endif

endmodule

// File: tb/tb_power_management.sv
// Directed self-checking bench for power_management (default parameters).
// Outputs are checked 1 ns after each rising edge as {clk_gate, isolation,
// reset_assert, pg_down}; sequencing invariants are checked on every step.
module tb_power_management;

  logic clk = 1'b0;
  logic reset;
  logic idle;
  logic interrupt;
  logic clk_gate, pg_down, reset_assert, isolation;
`ifdef PM_STATE_OBS_EN
  logic [2:0] pm_state;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  power_management dut (
    .clk          (clk),
    .reset        (reset),
    .idle         (idle),
    .interrupt    (interrupt),
    .clk_gate     (clk_gate),
    .pg_down      (pg_down),
    .reset_assert (reset_assert),
    .isolation    (isolation)
`ifdef PM_STATE_OBS_EN
    ,
    .pm_state     (pm_state)
`endif
  );

  task automatic chk(input string tag, input logic [3:0] exp);
    logic [3:0] got;
    got = {clk_gate, isolation, reset_assert, pg_down};
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%b exp=%b", tag, got, exp);
    end
  endtask

  task automatic chk_inv(input string tag);
    logic ok;
    ok = (!pg_down || reset_assert) && (!reset_assert || isolation) && (!isolation || clk_gate);
    total++;
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL inv_%s got=%b%b%b%b exp=ordered", tag, clk_gate, isolation,
             reset_assert, pg_down);
    end
  endtask

  // Advance one rising edge and check the resulting outputs.
  task automatic step(input string tag, input logic [3:0] exp);
    @(posedge clk);
    #1;
    chk(tag, exp);
    chk_inv(tag);
  endtask

  initial begin
    // Reset held with inputs high: everything stays low.
    reset = 1'b0; idle = 1'b1; interrupt = 1'b1;
    @(posedge clk); #1; chk("rst_c1", 4'b0000);
    @(posedge clk); #1; chk("rst_c2", 4'b0000);
    idle = 1'b0; interrupt = 1'b0; reset = 1'b1;
    step("rst_rel", 4'b0000);

    // Not idle: nothing happens.
    for (int i = 0; i < 5; i++) step("busy", 4'b0000);

    // Idle glitch restarts the count; gating on the 2nd consecutive idle edge.
    idle = 1'b1; step("idle1", 4'b0000);
    idle = 1'b0; step("glitch", 4'b0000);
    idle = 1'b1; step("idle1b", 4'b0000);
    step("gated", 4'b1000);

    // Deep power-down: iso, reset, power-off on successive edges.
    interrupt = 1'b1; step("iso", 4'b1100);
    step("rst", 4'b1110);
    step("pdn", 4'b1111);
    interrupt = 1'b0; step("pdn_hold", 4'b1111);

    // Wake: idle re-asserted during PUP must not shorten the sequence.
    idle = 1'b0; step("pup_w", 4'b1110);
    idle = 1'b1; step("pup_w1", 4'b1110);
    step("pup_w2", 4'b1110);
    step("pup_w3", 4'b1110);
    step("rrel_w4", 4'b1100);
    step("irel_w5", 4'b1000);
    step("active_w6", 4'b0000);
    // New idle period restarts from a cleared counter.
    step("reidle1", 4'b0000);
    step("regated", 4'b1000);

    // Abort during ISO: straight to isolation release, no reset pulse.
    interrupt = 1'b1; step("ab_iso", 4'b1100);
    idle = 1'b0; step("ab_irel", 4'b1000);
    interrupt = 1'b0; step("ab_active", 4'b0000);

    // Abort during RST: release reset, isolation, clock in order.
    idle = 1'b1; step("r_idle1", 4'b0000);
    step("r_gated", 4'b1000);
    interrupt = 1'b1; step("r_iso", 4'b1100);
    step("r_rst", 4'b1110);
    idle = 1'b0; step("r_rrel", 4'b1100);
    step("r_irel", 4'b1000);
    step("r_active", 4'b0000);

    // Async reset in PDN between edges.
    interrupt = 1'b0; idle = 1'b1; step("a_idle1", 4'b0000);
    step("a_gated", 4'b1000);
    interrupt = 1'b1; step("a_iso", 4'b1100);
    step("a_rst", 4'b1110);
    step("a_pdn", 4'b1111);
    #2; reset = 1'b0;
    #1; chk("async_rst", 4'b0000);
    idle = 1'b0; interrupt = 1'b1; reset = 1'b1;

    // Interrupt in ACTIVE is ignored; with idle it only reaches GATED first.
    step("int_act1", 4'b0000);
    step("int_act2", 4'b0000);
    idle = 1'b1; step("int_idle1", 4'b0000);
    step("int_gated", 4'b1000);
    step("int_iso", 4'b1100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
